rom_ctrl: RTL and testbench
===========================

# rom_ctrl

Parametrised on-chip instruction/data memory controller: word-organised storage with byte-strobed writes, a registered read port with a valid/ready handshake and back-pressure, and per-access address error reporting. Sits between the core's fetch/LSU bus and the memory array, replacing direct fixed-width dual-port RAM instantiation. An optional write-protect lock is available for freezing program memory after boot load.

## Interface
- DW, 32, data width in bits; multiple of 8, power of two ≥ 8
- AW, 32, byte-address width
- DEPTH, 4096, number of DW-bit words; power of two
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- wen  input  1  write request, single-cycle, always accepted
- w_addr  input  AW  byte address of write
- w_data  input  DW  write data
- w_strb  input  DW/8  byte enables; bit i writes w_data[8i+7:8i]
- w_err  output  1  one-cycle pulse: previous-cycle write rejected
- r_req  input  1  read request
- r_addr  input  AW  byte address of read
- r_gnt  output  1  read accepted this cycle when r_req && r_gnt
- r_valid  output  1  r_data/r_err valid
- r_ready  input  1  consumer accepts response
- r_data  output  DW  read data
- r_err  output  1  response is an error

## Operation
- OFS = log2(DW/8); IW = log2(DEPTH). Word index = addr[OFS+IW-1:OFS].
- Address error: addr[OFS-1:0] ≠ 0 (misaligned) or addr[AW-1:OFS+IW] ≠ 0 (out of range).
- Write: wen with no error → bytes with w_strb set updated at the clock edge; w_strb = 0 is a legal no-op. Write with error → array untouched, w_err = 1 next cycle.
- Read: accepted beat → response registered next cycle: r_valid = 1, r_data = array word (r_err = 0), or r_data = 0, r_err = 1 on address error.
- Back-pressure: r_gnt = !r_valid || r_ready (combinational). While r_valid && !r_ready, r_data/r_err/r_valid held stable and no new read accepted.
- Response retire: r_valid && r_ready with no new accepted request → r_valid = 0 next cycle; with new accepted request → back-to-back, r_valid stays 1, new data.
- Same-address read and write in one cycle: read returns old data (read-first); write completes.
- Array contents not reset; unwritten words return X in simulation.

## Timing
- Reset values: r_valid = 0, r_data = 0, r_err = 0, w_err = 0; r_gnt = 1 after reset.
- Read latency exactly 1 cycle from accepted beat to r_valid; throughput 1 read/cycle with r_ready held high.
- Write latency: data visible to a read accepted the following cycle.
- rst asserted mid-operation: pending response dropped (r_valid = 0 next cycle), in-flight write on the rst cycle is not performed, w_err cleared.
- r_req while r_gnt = 0 is ignored; requester must hold r_req/r_addr until granted.

## Configuration
- ROM_WPROT_EN defined: adds input wp_lock (1 bit). Lock register set on any cycle wp_lock = 1, cleared only by rst. While locked, every write is rejected (array untouched, w_err pulses) regardless of address; reads unaffected.
- ROM_WPROT_EN undefined: no wp_lock port, no lock register; w_err only reports address errors.

## Test plan
- Reset then write 0xDEADBEEF to 0x0000_0010 strb 4'hF, read 0x10 with r_ready = 1 → r_valid cycle after grant, r_data = 0xDEADBEEF, r_err = 0.
- Write 0x11223344 to 0x20 strb 4'hF, then 0xAABBCCDD strb 4'b0101 → read 0x20 returns 0x11BB33DD.
- Read 0x4002 (misaligned) and 0x0000_4000 (out of range, DEPTH = 4096) → r_err = 1, r_data = 0; write to 0x4000 → w_err = 1 next cycle, word 0 unchanged.
- Stream reads 0x0,0x4,0x8 with r_ready low for 3 cycles on second response → r_gnt = 0 during stall, second response held stable, third returned after release, no beat lost or duplicated.
- Same-cycle write 0x55 and read at 0x30 holding 0x99 → response 0x99; next read → 0x55.
- ROM_WPROT_EN: pulse wp_lock, write 0x1234 to 0x0 → w_err = 1, read returns old value; assert rst → lock cleared, write succeeds.

Source files
------------

// File: rtl/rom_ctrl_if.sv
// Write/read bus between a core requester and rom_ctrl.
// Read side is a valid/ready response channel with a combinational grant.
interface rom_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            wen;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_err;
  logic            r_req;
  logic [AW-1:0]   r_addr;
  logic            r_gnt;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic            r_err;

  modport master (
    output wen, w_addr, w_data, w_strb,
    output r_req, r_addr, r_ready,
    input  w_err, r_gnt, r_valid, r_data, r_err
  );

  modport slave (
    input  wen, w_addr, w_data, w_strb,
    input  r_req, r_addr, r_ready,
    output w_err, r_gnt, r_valid, r_data, r_err
  );
endinterface

// File: rtl/rom_ctrl.sv
// Word memory with byte-strobed writes and a registered, back-pressured read.
// Define ROM_WPROT_EN to add the wp_lock write-protect input.
module rom_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4096
) (
  input  logic clk,
  input  logic rst,
`ifdef ROM_WPROT_EN
  input  logic wp_lock,
`endif
  rom_ctrl_if.slave bus
);
  localparam int SW  = DW / 8;
  localparam int OFS = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [AW-1:0] LO_MASK = AW'((1 << OFS) - 1);

  logic [DW-1:0] mem [DEPTH];

  // Shifts and masks instead of slices so DW = 8 (OFS = 0) stays legal.
  function automatic logic bad_addr(input logic [AW-1:0] a);
    return ((a & LO_MASK) != '0) || ((a >> (OFS + IW)) != '0);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return IW'(a >> OFS);
  endfunction

  logic          locked;
  logic          w_bad;
  logic          w_ok;
  logic          r_bad;
  logic          accept;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;

`ifdef ROM_WPROT_EN
  logic lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (wp_lock) begin
      lock_q <= 1'b1;
    end
  end

  // The lock takes effect on the very cycle wp_lock is raised.
  assign locked = lock_q | wp_lock;
`else
  assign locked = 1'b0;
`endif

  assign w_bad  = bad_addr(bus.w_addr) | locked;
  assign w_ok   = bus.wen & ~w_bad;
  assign w_idx  = word_idx(bus.w_addr);
  assign r_bad  = bad_addr(bus.r_addr);
  assign r_idx  = word_idx(bus.r_addr);

  assign bus.r_gnt = ~bus.r_valid | bus.r_ready;
  assign accept    = bus.r_req & bus.r_gnt;

  always_ff @(posedge clk) begin
    if (!rst && w_ok) begin
      for (int i = 0; i < SW; i++) begin
        if (bus.w_strb[i]) begin
          mem[w_idx][8*i +: 8] <= bus.w_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.w_err <= 1'b0;
    end else begin
      bus.w_err <= bus.wen & w_bad;
    end
  end

  // Non-blocking read of mem gives read-first on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r_valid <= 1'b0;
      bus.r_data  <= '0;
      bus.r_err   <= 1'b0;
    end else if (accept) begin
      bus.r_valid <= 1'b1;
      bus.r_err   <= r_bad;
      bus.r_data  <= r_bad ? '0 : mem[r_idx];
    end else if (bus.r_ready) begin
      bus.r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rom_ctrl.sv
// Scoreboard bench for rom_ctrl: directed cases then random traffic
// against a word-array reference model.
module tb_rom_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wpl = 1'b0;

  always #5 clk = ~clk;

  rom_ctrl_if #(.DW(32), .AW(32)) bus ();

  rom_ctrl #(.DW(32), .AW(32), .DEPTH(4096)) dut (
    .clk (clk),
    .rst (rst),
`ifdef ROM_WPROT_EN
    .wp_lock (wpl),
`endif
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  int   total = 0;
  int   bad   = 0;
  rsp_t q[$];
  logic [31:0] mdl [16];
  logic mvalid   = 1'b0;
  logic mlock    = 1'b0;
  logic exp_werr = 1'b0;

  function automatic logic aerr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h4000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic rq, input logic [31:0] ra,
                       input logic rdy, input logic rs,
                       output logic g);
    logic gx;
    logic lk;
    chk("w_err", {31'b0, bus.w_err}, {31'b0, exp_werr});
    rst         = rs;
    bus.wen     = we;
    bus.w_addr  = wa;
    bus.w_data  = wd;
    bus.w_strb  = ws;
    bus.r_req   = rq;
    bus.r_addr  = ra;
    bus.r_ready = rdy;
    #1;
    gx = !mvalid || rdy;
    chk("r_gnt", {31'b0, bus.r_gnt}, {31'b0, gx});
    lk = 1'b0;
`ifdef ROM_WPROT_EN
    lk = mlock || wpl;
`endif
    g = 1'b0;
    if (rs) begin
      q.delete();
      mvalid   = 1'b0;
      exp_werr = 1'b0;
      mlock    = 1'b0;
    end else begin
      if (rq && gx) begin
        g = 1'b1;
        if (aerr(ra)) q.push_back('{32'h0, 1'b1});
        else q.push_back('{mdl[ra[5:2]], 1'b0});
        mvalid = 1'b1;
      end else if (rdy) begin
        mvalid = 1'b0;
      end
      exp_werr = we && (aerr(wa) || lk);
      if (we && !exp_werr) begin
        for (int i = 0; i < 4; i++)
          if (ws[i]) mdl[wa[5:2]][8*i +: 8] = wd[8*i +: 8];
      end
      if (wpl) mlock = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic g;
    cycle(1'b1, a, d, s, 1'b0, 32'h0, 1'b1, 1'b0, g);
  endtask

  task automatic rd(input logic [31:0] a);
    logic g;
    g = 1'b0;
    for (int k = 0; k < 10 && !g; k++)
      cycle(1'b0, 0, 0, 0, 1'b1, a, 1'b1, 1'b0, g);
    if (!g) begin
      total++;
      bad++;
      $display("FAIL read grant timeout: addr %h never granted", a);
    end
  endtask

  task automatic idle(input int n);
    logic g;
    for (int k = 0; k < n; k++)
      cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0, g);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 15)) * 4;
    if (r == 8) return 32'($urandom_range(0, 63)) | 32'h1;
    if ($urandom_range(0, 1) == 0)
      return 32'h4000 + 32'($urandom_range(0, 1000)) * 4;
    return 32'h8000_0000;
  endfunction

  // Monitor: pops the scoreboard on every consumed response beat.
  initial begin
    logic        hold;
    logic [31:0] hd;
    logic        he;
    rsp_t        e;
    hold = 1'b0;
    hd   = '0;
    he   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else if (bus.r_valid === 1'b1) begin
        if (hold) begin
          chk("held r_data", bus.r_data, hd);
          chk("held r_err", {31'b0, bus.r_err}, {31'b0, he});
        end
        if (bus.r_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra response: got data %h, none expected",
                     bus.r_data);
          end else begin
            e = q.pop_front();
            chk("r_data", bus.r_data, e.d);
            chk("r_err", {31'b0, bus.r_err}, {31'b0, e.e});
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hd   = bus.r_data;
          he   = bus.r_err;
        end
      end else begin
        if (hold) begin
          total++;
          bad++;
          $display("FAIL stall drop: r_valid %b want 1", bus.r_valid);
        end
        hold = 1'b0;
      end
    end
  end

  initial begin
    logic        g;
    logic        pend;
    logic [31:0] paddr;
    bus.wen     = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.w_strb  = '0;
    bus.r_req   = 1'b0;
    bus.r_addr  = '0;
    bus.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset r_valid", {31'b0, bus.r_valid}, 32'h0);
    chk("reset r_data", bus.r_data, 32'h0);
    chk("reset r_err", {31'b0, bus.r_err}, 32'h0);
    chk("reset w_err", {31'b0, bus.w_err}, 32'h0);
    chk("reset r_gnt", {31'b0, bus.r_gnt}, 32'h1);

    for (int i = 0; i < 16; i++) wr(32'(i) * 4, $urandom, 4'hF);

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);
    idle(1);
    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'b0101);
    rd(32'h20);
    rd(32'h4002);
    rd(32'h4000);
    wr(32'h4000, 32'hCAFEF00D, 4'hF);
    rd(32'h0);
    idle(2);

    cycle(1'b0, 0, 0, 0, 1'b1, 32'h0, 1'b1, 1'b0, g);
    cycle(1'b0, 0, 0, 0, 1'b1, 32'h4, 1'b1, 1'b0, g);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 0, 0, 0, 1'b1, 32'h8, 1'b0, 1'b0, g);
    rd(32'h8);
    idle(3);

    wr(32'h30, 32'h99, 4'hF);
    cycle(1'b1, 32'h30, 32'h55, 4'hF, 1'b1, 32'h30, 1'b1, 1'b0, g);
    rd(32'h30);
    idle(1);

    rd(32'h10);
    cycle(1'b1, 32'h10, 32'h0BAD0BAD, 4'hF, 1'b0, 0, 1'b1, 1'b1, g);
    rd(32'h10);
    idle(2);

`ifdef ROM_WPROT_EN
    wpl = 1'b1;
    idle(1);
    wpl = 1'b0;
    wr(32'h0, 32'h1234, 4'hF);
    rd(32'h0);
    idle(1);
    cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b1, g);
    wr(32'h0, 32'h1234, 4'hF);
    rd(32'h0);
    idle(2);
`endif

    pend  = 1'b0;
    paddr = '0;
    for (int n = 0; n < 3000; n++) begin
      logic rs;
      if (!pend) begin
        pend  = ($urandom_range(0, 1) == 1);
        paddr = rnd_addr();
      end
      rs = ($urandom_range(0, 299) == 0);
`ifdef ROM_WPROT_EN
      wpl = ($urandom_range(0, 499) == 0);
`endif
      cycle($urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            4'($urandom_range(0, 15)), pend, paddr,
            $urandom_range(0, 3) != 0, rs, g);
      if (g || rs) pend = 1'b0;
    end
    wpl = 1'b0;
    idle(4);
    chk("queue drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
